// File: rtl/cart_mapper_detect_pkg.sv
// Shared MSX cartridge definitions: mapper codes, detector FSM states and the
// bank-switch target addresses counted by the ROM mapper detector.
package cart_mapper_detect_pkg;

   localparam logic [5:0] MAPPER_LINEAR     = 6'd0;
   localparam logic [5:0] MAPPER_KONAMI     = 6'd1;
   localparam logic [5:0] MAPPER_KONAMI_SCC = 6'd2;
   localparam logic [5:0] MAPPER_ASCII8     = 6'd3;
   localparam logic [5:0] MAPPER_ASCII16    = 6'd4;

   typedef enum logic [2:0] {IDLE, SCAN, SCORE, DECIDE, RESULT} det_state_t;

   localparam int NUM_TARGETS = 11;

   localparam int T_4000 = 0;
   localparam int T_5000 = 1;
   localparam int T_6000 = 2;
   localparam int T_6800 = 3;
   localparam int T_7000 = 4;
   localparam int T_7800 = 5;
   localparam int T_77FF = 6;
   localparam int T_8000 = 7;
   localparam int T_9000 = 8;
   localparam int T_A000 = 9;
   localparam int T_B000 = 10;

   localparam logic [15:0] TALLY_ADDR [NUM_TARGETS] = '{
      16'h4000, 16'h5000, 16'h6000, 16'h6800, 16'h7000, 16'h7800,
      16'h77FF, 16'h8000, 16'h9000, 16'hA000, 16'hB000
   };

endpackage

// File: rtl/cart_mapper_tally.sv
// Byte-stream snooper: 3-byte window, "LD (nnnn),A" match and one saturating
// hit counter per bank-switch target address.
module cart_mapper_tally
   import cart_mapper_detect_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             wr,
   input  logic [24:0]      wr_addr,
   input  logic [7:0]       wr_data,
   output logic [CNT_W-1:0] counts [NUM_TARGETS]
);

   logic [7:0]  b2, b1, b0;
   logic [24:0] prev_addr;
   logic        gap;
   logic [7:0]  n2, n1;
   logic        match;
   logic [15:0] target;

   // A non-contiguous byte flushes the window so a match never spans a hole.
   always_comb begin
      gap    = (wr_addr != prev_addr + 25'd1);
      n2     = gap ? 8'h00 : b1;
      n1     = gap ? 8'h00 : b0;
      match  = wr && (n2 == 8'h32);
      target = {wr_data, n1};
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         b2        <= '0;
         b1        <= '0;
         b0        <= '0;
         prev_addr <= '0;
         for (int i = 0; i < NUM_TARGETS; i++) counts[i] <= '0;
      end else if (clear) begin
         b2        <= '0;
         b1        <= '0;
         b0        <= '0;
         prev_addr <= '0;
         for (int i = 0; i < NUM_TARGETS; i++) counts[i] <= '0;
      end else if (wr) begin
         b2        <= n2;
         b1        <= n1;
         b0        <= wr_data;
         prev_addr <= wr_addr;
         for (int i = 0; i < NUM_TARGETS; i++) begin
            if (match && target == TALLY_ADDR[i] && counts[i] != {CNT_W{1'b1}})
               counts[i] <= counts[i] + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cart_mapper_detect.sv
// Heuristic MSX ROM mapper detector: scores bank-switch writes seen during load.
// Optional header check enabled by defining CART_DETECT_HEADER_EN.
module cart_mapper_detect
   import cart_mapper_detect_pkg::*;
#(
   parameter int          CNT_W      = 8,
   parameter logic [31:0] LINEAR_MAX = 32'h10000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load_start,
   input  logic        load_done,
   input  logic        wr,
   input  logic [24:0] wr_addr,
   input  logic [7:0]  wr_data,
   output logic        busy,
   output logic        valid,
   output logic [5:0]  mapper,
   output logic        header_ok
);

   localparam int SW = CNT_W + 3;

   det_state_t       state, state_nx;
   logic             scan_wr;
   logic [25:0]      size, addr_p1;
   logic [CNT_W-1:0] counts [NUM_TARGETS];
   logic [SW-1:0]    s_kon, s_scc, s_a8, s_a16;
   logic [SW-1:0]    best_score;
   logic [5:0]       best;

   function automatic logic [SW-1:0] ext(input logic [CNT_W-1:0] c);
      return SW'(c);
   endfunction

   // A restart pulse discards any byte arriving in the same cycle.
   assign scan_wr = wr && (state == SCAN) && !load_start;
   assign addr_p1 = {1'b0, wr_addr} + 26'd1;
   assign busy    = (state == SCAN) || (state == SCORE) || (state == DECIDE);
   assign valid   = (state == RESULT);

   cart_mapper_tally #(.CNT_W(CNT_W)) u_tally (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (load_start),
      .wr      (scan_wr),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .counts  (counts)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (load_start) state_nx = SCAN;
      else begin
         case (state)
            SCAN:    if (load_done) state_nx = SCORE;
            SCORE:   state_nx = DECIDE;
            DECIDE:  state_nx = RESULT;
            default: state_nx = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        size <= '0;
      else if (load_start)                 size <= '0;
      else if (scan_wr && addr_p1 > size)  size <= addr_p1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_kon <= '0;
         s_scc <= '0;
         s_a8  <= '0;
         s_a16 <= '0;
      end else if (state == SCORE) begin
         s_kon <= ext(counts[T_4000]) + ext(counts[T_6000]) + ext(counts[T_8000]) + ext(counts[T_A000]);
         s_scc <= ext(counts[T_5000]) + ext(counts[T_7000]) + ext(counts[T_9000]) + ext(counts[T_B000]);
         s_a8  <= ext(counts[T_6000]) + ext(counts[T_6800]) + ext(counts[T_7000]) + ext(counts[T_7800]);
         s_a16 <= ext(counts[T_6000]) + ext(counts[T_7000]) + ext(counts[T_77FF]);
      end
   end

   `ifdef CART_DETECT_HEADER_EN
   logic [7:0] hdr0, hdr1;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hdr0 <= '0;
         hdr1 <= '0;
      end else if (load_start) begin
         hdr0 <= '0;
         hdr1 <= '0;
      end else if (scan_wr && wr_addr == 25'd0) hdr0 <= wr_data;
      else if (scan_wr && wr_addr == 25'd1)     hdr1 <= wr_data;
   end
   assign header_ok = (hdr0 == 8'h41) && (hdr1 == 8'h42);
   `else
   logic hdr_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) hdr_q <= 1'b0;
      else          hdr_q <= 1'b1;
   end
   assign header_ok = hdr_q;
   `endif

   // Strict '>' keeps the earlier candidate on ties: SCC > KONAMI > ASCII8 > ASCII16.
   // NOTE: every variable of this block is assigned first, so no latch is inferred.
   always_comb begin
      best       = MAPPER_KONAMI_SCC;
      best_score = s_scc;
      if (s_kon > best_score) begin
         best       = MAPPER_KONAMI;
         best_score = s_kon;
      end
      if (s_a8 > best_score) begin
         best       = MAPPER_ASCII8;
         best_score = s_a8;
      end
      if (s_a16 > best_score) begin
         best       = MAPPER_ASCII16;
         best_score = s_a16;
      end
      if (best_score == '0 || {6'd0, size} <= LINEAR_MAX) best = MAPPER_LINEAR;
      if (!header_ok) best = MAPPER_LINEAR;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)              mapper <= MAPPER_LINEAR;
      else if (state == DECIDE)  mapper <= best;
   end

endmodule

// File: tb/tb_cart_mapper_detect.sv
// Self-checking bench for cart_mapper_detect: table of images plus hand sequences,
// expected results queued when each load completes and popped when valid rises.
module tb_cart_mapper_detect;
   import cart_mapper_detect_pkg::*;

   `ifdef CART_DETECT_HEADER_EN
   localparam bit HDR_EN = 1'b1;
   `else
   localparam bit HDR_EN = 1'b0;
   `endif

   logic        clk = 1'b0;
   logic        reset_n, load_start, load_done, wr;
   logic [24:0] wr_addr;
   logic [7:0]  wr_data;
   logic        busy, valid, header_ok;
   logic [5:0]  mapper;

   int errors = 0;
   int checks = 0;
   int unsigned waddr;

   typedef struct {
      string       name;
      int unsigned size;
      logic [7:0]  h0, h1;
      logic [15:0] t0, t1, t2;
      int          n0, n1, n2;
      logic [5:0]  exp_mapper;
      logic        exp_hdr;
   } vec_t;

   typedef struct {
      logic [5:0] m;
      logic       h;
   } exp_t;

   vec_t vecs [10];
   exp_t sb [$];

   cart_mapper_detect dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_start (load_start),
      .load_done  (load_done),
      .wr         (wr),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .valid      (valid),
      .mapper     (mapper),
      .header_ok  (header_ok)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic put_byte(input int unsigned a, input logic [7:0] d);
      wr      = 1'b1;
      wr_addr = 25'(a);
      wr_data = d;
      @(negedge clk);
      wr      = 1'b0;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic pattern(input logic [15:0] t, input int n);
      for (int i = 0; i < n; i++) begin
         put_byte(waddr, 8'h32);     waddr++;
         put_byte(waddr, t[7:0]);    waddr++;
         put_byte(waddr, t[15:8]);   waddr++;
      end
   endtask

   task automatic finish_load(input string name, input logic [5:0] em, input logic eh);
      exp_t e;
      int   cyc;
      e.m = em;
      e.h = eh;
      sb.push_back(e);
      load_done = 1'b1;
      @(negedge clk);
      load_done = 1'b0;
      for (cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (valid) break;
      end
      check({name, " latency"}, 32'(cyc), 32'd2);
      e = sb.pop_front();
      check({name, " mapper"}, 32'(mapper), 32'(e.m));
      check({name, " header_ok"}, 32'(header_ok), 32'(e.h));
      check({name, " busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [5:0] cd_m;
      cd_m = HDR_EN ? MAPPER_LINEAR : MAPPER_KONAMI_SCC;
      vecs[0] = '{"konami_scc", 32'h20000, 8'h41, 8'h42, 16'h5000, 16'h9000, 16'h6000, 5, 5, 2, MAPPER_KONAMI_SCC, 1'b1};
      vecs[1] = '{"ascii8",     32'h20000, 8'h41, 8'h42, 16'h6800, 16'h7800, 16'h6000, 3, 3, 1, MAPPER_ASCII8, 1'b1};
      vecs[2] = '{"ascii16",    32'h20000, 8'h41, 8'h42, 16'h77FF, 16'h7000, 16'h0000, 3, 2, 0, MAPPER_ASCII16, 1'b1};
      vecs[3] = '{"tie",        32'h20000, 8'h41, 8'h42, 16'h4000, 16'h5000, 16'h0000, 2, 2, 0, MAPPER_KONAMI_SCC, 1'b1};
      vecs[4] = '{"linear_16k", 32'h04000, 8'h41, 8'h42, 16'h5000, 16'h0000, 16'h0000, 5, 0, 0, MAPPER_LINEAR, 1'b1};
      vecs[5] = '{"no_match",   32'h20000, 8'h41, 8'h42, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, MAPPER_LINEAR, 1'b1};
      vecs[6] = '{"size_64k",   32'h10000, 8'h41, 8'h42, 16'h5000, 16'h0000, 16'h0000, 5, 0, 0, MAPPER_LINEAR, 1'b1};
      vecs[7] = '{"size_64k_1", 32'h10001, 8'h41, 8'h42, 16'h5000, 16'h0000, 16'h0000, 5, 0, 0, MAPPER_KONAMI_SCC, 1'b1};
      vecs[8] = '{"saturate",   32'h20000, 8'h41, 8'h42, 16'h8000, 16'h9000, 16'h0000, 300, 100, 0, MAPPER_KONAMI, 1'b1};
      vecs[9] = '{"cd_header",  32'h20000, 8'h43, 8'h44, 16'h5000, 16'h0000, 16'h0000, 5, 0, 0, cd_m, !HDR_EN};

      reset_n = 1'b0; load_start = 1'b0; load_done = 1'b0;
      wr = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset valid", 32'(valid), 32'd0);
      check("reset mapper", 32'(mapper), 32'(MAPPER_LINEAR));
      check("reset header_ok", 32'(header_ok), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("post-reset header_ok", 32'(header_ok), HDR_EN ? 32'd0 : 32'd1);

      for (int v = 0; v < 10; v++) begin
         start_load();
         check({vecs[v].name, " busy in scan"}, 32'(busy), 32'd1);
         check({vecs[v].name, " valid in scan"}, 32'(valid), 32'd0);
         put_byte(0, vecs[v].h0);
         put_byte(1, vecs[v].h1);
         waddr = 2;
         pattern(vecs[v].t0, vecs[v].n0);
         pattern(vecs[v].t1, vecs[v].n1);
         pattern(vecs[v].t2, vecs[v].n2);
         put_byte(vecs[v].size - 1, 8'hFF);
         finish_load(vecs[v].name, vecs[v].exp_mapper, vecs[v].exp_hdr);
      end

      // Gapped "32 | 00 80" must not count; one contiguous SCC hit wins.
      start_load();
      put_byte(0, 8'h41); put_byte(1, 8'h42);
      waddr = 2;
      pattern(16'h5000, 1);
      for (int i = 0; i < 3; i++) begin
         put_byte(waddr, 8'h32); waddr += 2;
         put_byte(waddr, 8'h00); waddr++;
         put_byte(waddr, 8'h80); waddr++;
      end
      put_byte(32'h1FFFF, 8'hFF);
      finish_load("gap", MAPPER_KONAMI_SCC, 1'b1);

      // Restart mid-scan discards the ASCII8 hits.
      start_load();
      put_byte(0, 8'h41); put_byte(1, 8'h42);
      waddr = 2;
      pattern(16'h6800, 3);
      pattern(16'h7800, 3);
      start_load();
      check("restart busy", 32'(busy), 32'd1);
      put_byte(0, 8'h41); put_byte(1, 8'h42);
      waddr = 2;
      pattern(16'h4000, 3);
      pattern(16'hA000, 2);
      put_byte(32'h1FFFF, 8'hFF);
      finish_load("restart", MAPPER_KONAMI, 1'b1);

      // load_done in RESULT is ignored; result holds.
      load_done = 1'b1;
      @(negedge clk);
      load_done = 1'b0;
      repeat (3) @(negedge clk);
      check("held valid", 32'(valid), 32'd1);
      check("held mapper", 32'(mapper), 32'(MAPPER_KONAMI));
      check("held busy", 32'(busy), 32'd0);

      // Asynchronous reset in the middle of a load.
      start_load();
      put_byte(0, 8'h41); put_byte(1, 8'h42);
      waddr = 2;
      pattern(16'h5000, 2);
      #2 reset_n = 1'b0;
      #1;
      check("midload reset busy", 32'(busy), 32'd0);
      check("midload reset valid", 32'(valid), 32'd0);
      check("midload reset mapper", 32'(mapper), 32'(MAPPER_LINEAR));
      check("midload reset header_ok", 32'(header_ok), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("scoreboard empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
